// File: rtl/discus_loader_if.sv
// Command and response byte streams between a host and discus_loader.
interface discus_loader_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;

  modport master (
    output cmd_data, cmd_valid, rsp_ready,
    input  cmd_ready, rsp_data, rsp_valid
  );

  modport slave (
    input  cmd_data, cmd_valid, rsp_ready,
    output cmd_ready, rsp_data, rsp_valid
  );
endinterface

// File: rtl/discus_loader.sv
// Byte-command loader: sets an address, writes data/program memory, reads data memory, holds the CPU in reset.
// Optional macro DISCUS_LOADER_ACK_EN adds 0xA5 acknowledges (and 0xEE for unknown opcodes).
module discus_loader #(
  parameter logic        CPU_RST_INIT = 1'b1,
  parameter int unsigned READ_LAT     = 2
) (
  input  logic                  memclk,
  input  logic                  reset,
  discus_loader_if.slave        bus,
  output logic [7:0]            o_snoopa,
  output logic [7:0]            o_snoopd,
  output logic                  o_snoopm,
  output logic                  o_snoopp,
  input  logic [7:0]            i_snoopq,
  output logic                  o_cpu_reset
);

  localparam logic [7:0] OP_SETADDR = 8'h01;
  localparam logic [7:0] OP_WMEM    = 8'h02;
  localparam logic [7:0] OP_WPRG    = 8'h03;
  localparam logic [7:0] OP_RMEM    = 8'h04;
  localparam logic [7:0] OP_HALT    = 8'h05;
  localparam logic [7:0] OP_RUN     = 8'h06;

  // Counter counts down to zero; capture happens on the edge that sees zero.
  localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);

`ifdef DISCUS_LOADER_ACK_EN
  localparam logic [7:0] RSP_ACK  = 8'hA5;
  localparam logic [7:0] RSP_NACK = 8'hEE;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARG,
    S_STROBE,
    S_RWAIT,
    S_RSP
  } state_e;

  state_e     r_state;
  state_e     w_state_nx;
  logic [7:0] r_op;
  logic [7:0] w_op_nx;
  logic [7:0] r_addr;
  logic [7:0] w_addr_nx;
  logic [7:0] r_snoopd;
  logic [7:0] w_snoopd_nx;
  logic       r_snoopm;
  logic       w_snoopm_nx;
  logic       r_snoopp;
  logic       w_snoopp_nx;
  logic [7:0] r_rsp_data;
  logic [7:0] w_rsp_data_nx;
  logic       r_rsp_valid;
  logic       w_rsp_valid_nx;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nx;
  logic       r_cpu_reset;
  logic       w_cpu_reset_nx;
  logic       r_cmd_ready;
  logic       w_cmd_ready_nx;
  logic       w_cmd_fire;

  assign w_cmd_fire = bus.cmd_valid && r_cmd_ready;

  always_ff @(posedge memclk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_addr      <= '0;
      r_snoopd    <= '0;
      r_snoopm    <= 1'b0;
      r_snoopp    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_cnt       <= '0;
      r_cpu_reset <= CPU_RST_INIT;
      r_cmd_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_op        <= w_op_nx;
      r_addr      <= w_addr_nx;
      r_snoopd    <= w_snoopd_nx;
      r_snoopm    <= w_snoopm_nx;
      r_snoopp    <= w_snoopp_nx;
      r_rsp_data  <= w_rsp_data_nx;
      r_rsp_valid <= w_rsp_valid_nx;
      r_cnt       <= w_cnt_nx;
      r_cpu_reset <= w_cpu_reset_nx;
      r_cmd_ready <= w_cmd_ready_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_op_nx        = r_op;
    w_addr_nx      = r_addr;
    w_snoopd_nx    = r_snoopd;
    w_snoopm_nx    = 1'b0;
    w_snoopp_nx    = 1'b0;
    w_rsp_data_nx  = r_rsp_data;
    w_rsp_valid_nx = r_rsp_valid;
    w_cnt_nx       = r_cnt;
    w_cpu_reset_nx = r_cpu_reset;

    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          w_op_nx = bus.cmd_data;
          case (bus.cmd_data)
            OP_SETADDR, OP_WMEM, OP_WPRG: w_state_nx = S_ARG;
            OP_RMEM: begin
              w_cnt_nx   = LAT_LOAD;
              w_state_nx = S_RWAIT;
            end
            OP_HALT: begin
              w_cpu_reset_nx = 1'b1;
`ifdef DISCUS_LOADER_ACK_EN
              w_rsp_data_nx  = RSP_ACK;
              w_rsp_valid_nx = 1'b1;
              w_state_nx     = S_RSP;
`endif
            end
            OP_RUN: begin
              w_cpu_reset_nx = 1'b0;
`ifdef DISCUS_LOADER_ACK_EN
              w_rsp_data_nx  = RSP_ACK;
              w_rsp_valid_nx = 1'b1;
              w_state_nx     = S_RSP;
`endif
            end
            default: begin
`ifdef DISCUS_LOADER_ACK_EN
              w_rsp_data_nx  = RSP_NACK;
              w_rsp_valid_nx = 1'b1;
              w_state_nx     = S_RSP;
`endif
            end
          endcase
        end
      end

      S_ARG: begin
        if (w_cmd_fire) begin
          if (r_op == OP_SETADDR) begin
            w_addr_nx  = bus.cmd_data;
            w_state_nx = S_IDLE;
`ifdef DISCUS_LOADER_ACK_EN
            w_rsp_data_nx  = RSP_ACK;
            w_rsp_valid_nx = 1'b1;
            w_state_nx     = S_RSP;
`endif
          end else begin
            // Only WMEM/WPRG reach here, so exactly one strobe is raised.
            w_snoopd_nx = bus.cmd_data;
            w_snoopm_nx = (r_op == OP_WMEM);
            w_snoopp_nx = (r_op != OP_WMEM);
            w_state_nx  = S_STROBE;
          end
        end
      end

      S_STROBE: begin
        w_addr_nx  = r_addr + 8'd1;
        w_state_nx = S_IDLE;
`ifdef DISCUS_LOADER_ACK_EN
        w_rsp_data_nx  = RSP_ACK;
        w_rsp_valid_nx = 1'b1;
        w_state_nx     = S_RSP;
`endif
      end

      S_RWAIT: begin
        if (r_cnt == 3'd0) begin
          w_rsp_data_nx  = i_snoopq;
          w_rsp_valid_nx = 1'b1;
          w_addr_nx      = r_addr + 8'd1;
          w_state_nx     = S_RSP;
        end else begin
          w_cnt_nx = r_cnt - 3'd1;
        end
      end

      S_RSP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_nx = 1'b0;
          w_state_nx     = S_IDLE;
        end
      end

      default: w_state_nx = S_IDLE;
    endcase

    w_cmd_ready_nx = (w_state_nx == S_IDLE) || (w_state_nx == S_ARG);
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_valid = r_rsp_valid;
  assign o_snoopa      = r_addr;
  assign o_snoopd      = r_snoopd;
  assign o_snoopm      = r_snoopm;
  assign o_snoopp      = r_snoopp;
  assign o_cpu_reset   = r_cpu_reset;

endmodule

// File: tb/tb_discus_loader.sv
// Directed and randomized bench for discus_loader against a behavioural memory/address model.
module tb_discus_loader;
  localparam int unsigned LAT      = 3;
  localparam logic        RST_INIT = 1'b1;

  logic       memclk = 1'b0;
  logic       reset;
  logic [7:0] snoopa, snoopd, snoopq;
  logic       snoopm, snoopp, cpu_reset;

  discus_loader_if bus ();

  discus_loader #(
    .CPU_RST_INIT(RST_INIT),
    .READ_LAT    (LAT)
  ) dut (
    .memclk     (memclk),
    .reset      (reset),
    .bus        (bus),
    .o_snoopa   (snoopa),
    .o_snoopd   (snoopd),
    .o_snoopm   (snoopm),
    .o_snoopp   (snoopp),
    .i_snoopq   (snoopq),
    .o_cpu_reset(cpu_reset)
  );

  always #5 memclk = ~memclk;

  // Target data memory: registered read of snoopa, written by snoopm.
  logic [7:0] tmem [256];
  always @(posedge memclk) begin
    snoopq <= tmem[snoopa];
    if (snoopm) tmem[snoopa] = snoopd;
  end

  int unsigned strobe_cnt = 0;
  logic        both_seen  = 1'b0;
  always @(negedge memclk) begin
    if (snoopm || snoopp) strobe_cnt++;
    if (snoopm && snoopp) both_seen = 1'b1;
  end

  // Reference model state
  logic [7:0]  ref_dmem [256];
  logic [7:0]  ref_addr;
  logic        ref_cpu;
  int unsigned exp_strobes = 0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge memclk);
    bus.cmd_data  = b;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge memclk);
      n++;
    end
    if (!bus.cmd_ready) begin
      chk("cmd_accept_timeout", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge memclk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // Returns at the negedge where rsp_valid is first seen; lat = edges after acceptance.
  task automatic get_rsp(output logic [7:0] d, output int lat);
    int k = 0;
    @(negedge memclk);
    while (!bus.rsp_valid && k < 50) begin
      k++;
      @(negedge memclk);
    end
    chk("rsp_seen", bus.rsp_valid, 1);
    d   = bus.rsp_data;
    lat = k;
  endtask

  // Called at the negedge after a non-read command completes.
  task automatic after_cmd(input logic [7:0] ack_val);
`ifdef DISCUS_LOADER_ACK_EN
    chk("ack_valid", bus.rsp_valid, 1);
    chk("ack_data", bus.rsp_data, ack_val);
    @(posedge memclk);
    @(negedge memclk);
    chk("ack_drop", bus.rsp_valid, 0);
    chk("ack_ready_after", bus.cmd_ready, 1);
`else
    chk("no_rsp", bus.rsp_valid, 0);
    chk("ready_after_cmd", bus.cmd_ready, (ack_val != 8'h00) ? 1 : 0);
`endif
  endtask

  task automatic do_setaddr(input logic [7:0] a);
    send_byte(8'h01);
    send_byte(a);
    ref_addr = a;
    @(negedge memclk);
    chk("setaddr_snoopa", snoopa, ref_addr);
    after_cmd(8'hA5);
  endtask

  task automatic do_write(input logic isprg, input logic [7:0] d);
    send_byte(isprg ? 8'h03 : 8'h02);
    send_byte(d);
    @(negedge memclk);
    chk("wr_snoopm", snoopm, !isprg);
    chk("wr_snoopp", snoopp, isprg);
    chk("wr_snoopa", snoopa, ref_addr);
    chk("wr_snoopd", snoopd, d);
    exp_strobes++;
    if (!isprg) ref_dmem[ref_addr] = d;
    ref_addr = ref_addr + 8'd1;
    @(negedge memclk);
    chk("wr_strobe_end", {snoopm, snoopp}, 2'b00);
    chk("wr_addr_inc", snoopa, ref_addr);
    chk("wr_snoopd_hold", snoopd, d);
    after_cmd(8'hA5);
  endtask

  task automatic do_rmem();
    logic [7:0] d;
    int         lat;
    logic [7:0] exp;
    exp = ref_dmem[ref_addr];
    send_byte(8'h04);
    get_rsp(d, lat);
    chk("rmem_latency", lat, LAT);
    chk("rmem_data", d, exp);
    ref_addr = ref_addr + 8'd1;
    chk("rmem_addr_inc", snoopa, ref_addr);
    @(posedge memclk);
    @(negedge memclk);
    chk("rmem_drop", bus.rsp_valid, 0);
    chk("rmem_ready", bus.cmd_ready, 1);
  endtask

  task automatic do_ctl(input logic [7:0] op);
    send_byte(op);
    if (op == 8'h05) ref_cpu = 1'b1;
    if (op == 8'h06) ref_cpu = 1'b0;
    @(negedge memclk);
    chk("ctl_cpu_reset", cpu_reset, ref_cpu);
    chk("ctl_snoopa", snoopa, ref_addr);
    after_cmd((op == 8'h05 || op == 8'h06) ? 8'hA5 : 8'hEE);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge memclk);
    @(negedge memclk);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_strobes", {snoopm, snoopp}, 2'b00);
    chk("rst_snoopa", snoopa, 0);
    chk("rst_snoopd", snoopd, 0);
    chk("rst_cpu_reset", cpu_reset, RST_INIT);
    reset    = 1'b0;
    ref_addr = 8'h00;
    ref_cpu  = RST_INIT;
    @(negedge memclk);
    chk("rst_ready_after", bus.cmd_ready, 1);
  endtask

  initial begin
    logic [7:0]  d0;
    int          lat;
    int unsigned snap;
    logic        seen;

    for (int i = 0; i < 256; i++) begin
      tmem[i]     = 8'($urandom);
      ref_dmem[i] = tmem[i];
    end
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge memclk);
    apply_reset();

    // Program RAM writes with auto-increment
    do_setaddr(8'h10);
    do_write(1'b1, 8'h3C);
    do_write(1'b1, 8'h41);
    chk("prg_final_addr", snoopa, 8'h12);

    // Write then read back
    do_setaddr(8'h20);
    do_write(1'b0, 8'h99);
    do_setaddr(8'h20);
    do_rmem();
    chk("readback_mem", tmem[8'h20], 8'h99);

    // Address wrap
    do_setaddr(8'hFF);
    do_write(1'b0, 8'h01);
    chk("wrap_addr", snoopa, 8'h00);
    do_write(1'b0, 8'h02);
    chk("wrap_mem_ff", tmem[8'hFF], 8'h01);
    chk("wrap_mem_00", tmem[8'h00], 8'h02);

    // Response back-pressure with a stalled command waiting
    do_setaddr(8'h20);
    bus.rsp_ready = 1'b0;
    send_byte(8'h04);
    get_rsp(d0, lat);
    chk("stall_latency", lat, LAT);
    chk("stall_data", d0, 8'h99);
    ref_addr = ref_addr + 8'd1;
    bus.cmd_data  = 8'h01;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge memclk);
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_data_hold", bus.rsp_data, d0);
      chk("stall_cmd_ready", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    send_byte(8'h01);
    @(negedge memclk);
    chk("stall_rsp_dropped", bus.rsp_valid, 0);
    send_byte(8'h77);
    ref_addr = 8'h77;
    @(negedge memclk);
    after_cmd(8'hA5);
    do_write(1'b0, 8'h5A);

    // CPU hold control and unknown opcode
    do_ctl(8'h06);
    do_ctl(8'h05);
    do_ctl(8'h06);
    do_ctl(8'h7F);

    // Reset during STROBE
    do_setaddr(8'h30);
    send_byte(8'h02);
    send_byte(8'hAB);
    @(negedge memclk);
    chk("pre_rst_strobe", snoopm, 1);
    ref_dmem[8'h30] = 8'hAB;
    exp_strobes++;
    reset = 1'b1;
    @(posedge memclk);
    #1 snap = strobe_cnt;
    @(negedge memclk);
    chk("strobe_rst_snoopm", snoopm, 0);
    chk("strobe_rst_cpu", cpu_reset, RST_INIT);
    chk("strobe_rst_valid", bus.rsp_valid, 0);
    chk("strobe_rst_addr", snoopa, 0);
    reset    = 1'b0;
    ref_addr = 8'h00;
    ref_cpu  = RST_INIT;
    repeat (3) @(posedge memclk);
    #1 chk("strobe_rst_no_more", strobe_cnt, snap);

    // Reset during RWAIT
    do_ctl(8'h06);
    send_byte(8'h04);
    @(negedge memclk);
    reset = 1'b1;
    @(posedge memclk);
    @(negedge memclk);
    chk("rwait_rst_valid", bus.rsp_valid, 0);
    chk("rwait_rst_cpu", cpu_reset, RST_INIT);
    chk("rwait_rst_addr", snoopa, 0);
    reset    = 1'b0;
    ref_addr = 8'h00;
    ref_cpu  = RST_INIT;
    seen     = 1'b0;
    repeat (6) begin
      @(negedge memclk);
      seen = seen | bus.rsp_valid;
    end
    chk("rwait_rsp_discarded", seen, 0);

    // Reset after a bare opcode: partial command discarded
    send_byte(8'h02);
    @(negedge memclk);
    reset = 1'b1;
    @(posedge memclk);
    @(negedge memclk);
    reset    = 1'b0;
    ref_addr = 8'h00;
    do_setaddr(8'h40);
    do_write(1'b0, 8'h55);

    // Randomized command mix
    for (int i = 0; i < 40; i++) begin
      int unsigned sel;
      logic [7:0]  v;
      sel = $urandom_range(0, 3);
      v   = 8'($urandom);
      case (sel)
        0: do_setaddr((i % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(250, 255)));
        1: do_write(1'b0, v);
        2: do_write(1'b1, v);
        default: do_rmem();
      endcase
    end

    repeat (2) @(negedge memclk);
    chk("strobe_exclusive", both_seen, 0);
    chk("strobe_count", strobe_cnt, exp_strobes);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
